// File: rtl/rojobot_io_master.sv
`default_nettype none
// ============================================================================
//  Module   : rojobot_io_master
//  Purpose  : I/O-bus master servicing the RojoBot register block. On an
//             enabled interrupt it acknowledges, reads the four bot
//             registers (LocX, LocY, BotInfo, Sensors) into snapshot
//             registers, mirrors LocX/LocY onto the LED ports and pulses
//             snap_valid. Motor commands are latched and written to MotCtl
//             when no service is running.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             enable, interrupt   - service enable, update-request level
//             interrupt_ack       - one-cycle acknowledge
//             port_id, read_strobe, write_strobe, out_port, in_port
//                                 - I/O bus (in_port registered by responder)
//             mot_req, mot_cmd, mot_ack - motor command request/ack
//             loc_x, loc_y, bot_info, sensors - snapshot registers
//             snap_valid, snap_count, busy - snapshot status
//  Revision : 1.0 - initial release
// ============================================================================
module rojobot_io_master (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       interrupt,
  output logic       interrupt_ack,
  output logic [7:0] port_id,
  output logic       read_strobe,
  output logic       write_strobe,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  input  logic       mot_req,
  input  logic [7:0] mot_cmd,
  output logic       mot_ack,
  output logic [7:0] loc_x,
  output logic [7:0] loc_y,
  output logic [7:0] bot_info,
  output logic [7:0] sensors,
  output logic       snap_valid,
  output logic [7:0] snap_count,
  output logic       busy
);

  localparam logic [7:0] PA_LOCX    = 8'h0A;
  localparam logic [7:0] PA_MOTCTL  = 8'h09;
  localparam logic [7:0] PA_LED_LO  = 8'h02;
  localparam logic [7:0] PA_LED_HI  = 8'h12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACK       = 3'd1,
    RD_SETUP  = 3'd2,
    RD_SAMPLE = 3'd3,
    WR_LED_LO = 3'd4,
    WR_LED_HI = 3'd5,
    DONE      = 3'd6,
    WR_MOT    = 3'd7
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] rd_idx;
  logic       mot_pend;
  logic [7:0] mot_reg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Read index walks 0..3 across the four RD_SETUP/RD_SAMPLE pairs
  always_ff @(posedge clk) begin
    if (reset)
      rd_idx <= 2'd0;
    else if (state == ACK)
      rd_idx <= 2'd0;
    else if (state == RD_SAMPLE && rd_idx != 2'd3)
      rd_idx <= rd_idx + 2'd1;
  end

  // Snapshot capture: in_port is valid during RD_SAMPLE because the
  // responder registered it off the port_id presented in RD_SETUP.
  always_ff @(posedge clk) begin
    if (reset) begin
      loc_x    <= 8'h00;
      loc_y    <= 8'h00;
      bot_info <= 8'h00;
      sensors  <= 8'h00;
    end else if (state == RD_SAMPLE) begin
      case (rd_idx)
        2'd0:    loc_x    <= in_port;
        2'd1:    loc_y    <= in_port;
        2'd2:    bot_info <= in_port;
        default: sensors  <= in_port;
      endcase
    end
  end

  // Motor command latch: a new request always wins, so a request that
  // arrives in the WR_MOT cycle re-arms the pending flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mot_pend <= 1'b0;
      mot_reg  <= 8'h00;
    end else if (mot_req) begin
      mot_pend <= 1'b1;
      mot_reg  <= mot_cmd;
    end else if (state == WR_MOT) begin
      mot_pend <= 1'b0;
    end
  end

  // Completed-snapshot counter, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (reset)              snap_count <= 8'h00;
    else if (state == DONE) snap_count <= snap_count + 8'h01;
  end

  // Next state and bus decode; outputs depend only on registered values
  always_comb begin
    state_next    = state;
    interrupt_ack = 1'b0;
    port_id       = 8'h00;
    read_strobe   = 1'b0;
    write_strobe  = 1'b0;
    out_port      = 8'h00;
    mot_ack       = 1'b0;
    snap_valid    = 1'b0;
    busy          = (state != IDLE);

    case (state)
      IDLE: begin
        if (interrupt && enable) state_next = ACK;
        else if (mot_pend)       state_next = WR_MOT;
      end
      ACK: begin
        interrupt_ack = 1'b1;
        state_next    = RD_SETUP;
      end
      RD_SETUP: begin
        port_id    = PA_LOCX + {6'd0, rd_idx};
        state_next = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        port_id     = PA_LOCX + {6'd0, rd_idx};
        read_strobe = 1'b1;
        state_next  = (rd_idx == 2'd3) ? WR_LED_LO : RD_SETUP;
      end
      WR_LED_LO: begin
        port_id      = PA_LED_LO;
        out_port     = loc_x;
        write_strobe = 1'b1;
        state_next   = WR_LED_HI;
      end
      WR_LED_HI: begin
        port_id      = PA_LED_HI;
        out_port     = loc_y;
        write_strobe = 1'b1;
        state_next   = DONE;
      end
      DONE: begin
        snap_valid = 1'b1;
        state_next = IDLE;
      end
      WR_MOT: begin
        port_id      = PA_MOTCTL;
        out_port     = mot_reg;
        write_strobe = 1'b1;
        mot_ack      = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rojobot_io_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rojobot_io_master
//  Purpose  : Self-checking bench for rojobot_io_master. A responder returns
//             per-register values one clock after port_id; a timeline model
//             (cycle offset within a service) predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rojobot_io_master;

  logic       clk = 1'b0;
  logic       reset, enable, interrupt, mot_req;
  logic [7:0] mot_cmd, in_port;
  logic       interrupt_ack, read_strobe, write_strobe, mot_ack, snap_valid, busy;
  logic [7:0] port_id, out_port, loc_x, loc_y, bot_info, sensors, snap_count;

  rojobot_io_master dut (
    .clk(clk), .reset(reset), .enable(enable), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
    .mot_req(mot_req), .mot_cmd(mot_cmd), .mot_ack(mot_ack),
    .loc_x(loc_x), .loc_y(loc_y), .bot_info(bot_info), .sensors(sensors),
    .snap_valid(snap_valid), .snap_count(snap_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: register file at 0x0A..0x0D, data registered one clock later
  logic [7:0] resp_val [4];
  logic [1:0] resp_idx;
  always_comb resp_idx = port_id[1:0] + 2'd2;
  always @(posedge clk) begin
    if (port_id >= 8'h0A && port_id <= 8'h0D) in_port <= resp_val[resp_idx];
    else                                       in_port <= 8'hEE;
  end

  int vectors = 0;
  int miscompares = 0;
  int mack_cnt = 0;
  logic [7:0] mack_data = 8'h00;

  // Reference model: position in a service timeline.
  // -1 idle, 0 ack, 1..8 read pairs, 9/10 LED writes, 11 done, 100 motor write
  localparam int PH_IDLE = -1;
  localparam int PH_MOT  = 100;
  int         m_phase = PH_IDLE;
  logic       m_pend  = 1'b0;
  logic [7:0] m_reg   = 8'h00;
  logic [7:0] m_loc [4];
  logic [7:0] m_count = 8'h00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic pend_old;
    pend_old = m_pend;
    if (reset) begin
      m_phase = PH_IDLE;
      m_pend  = 1'b0;
      m_reg   = 8'h00;
      for (int i = 0; i < 4; i++) m_loc[i] = 8'h00;
      m_count = 8'h00;
    end else begin
      if (mot_req) begin
        m_pend = 1'b1;
        m_reg  = mot_cmd;
      end else if (m_phase == PH_MOT) begin
        m_pend = 1'b0;
      end
      if (m_phase == PH_IDLE) begin
        if (interrupt && enable) m_phase = 0;
        else if (pend_old)       m_phase = PH_MOT;
      end else if (m_phase == PH_MOT) begin
        m_phase = PH_IDLE;
      end else if (m_phase == 11) begin
        m_count = m_count + 8'h01;
        m_phase = PH_IDLE;
      end else begin
        if (m_phase >= 1 && m_phase <= 8 && ((m_phase - 1) % 2) == 1)
          m_loc[(m_phase - 1) / 2] = resp_val[(m_phase - 1) / 2];
        m_phase++;
      end
    end
  endtask

  task automatic model_check();
    logic [7:0] e_port, e_out;
    logic       e_ack, e_rs, e_ws, e_mack, e_sv, e_busy;
    e_port = 8'h00; e_out = 8'h00;
    e_ack = 1'b0; e_rs = 1'b0; e_ws = 1'b0; e_mack = 1'b0; e_sv = 1'b0;
    e_busy = (m_phase != PH_IDLE);
    if (m_phase == PH_MOT) begin
      e_port = 8'h09; e_out = m_reg; e_ws = 1'b1; e_mack = 1'b1;
    end else if (m_phase == 0) begin
      e_ack = 1'b1;
    end else if (m_phase >= 1 && m_phase <= 8) begin
      e_port = 8'h0A + 8'((m_phase - 1) / 2);
      e_rs   = ((m_phase - 1) % 2) == 1;
    end else if (m_phase == 9) begin
      e_port = 8'h02; e_out = m_loc[0]; e_ws = 1'b1;
    end else if (m_phase == 10) begin
      e_port = 8'h12; e_out = m_loc[1]; e_ws = 1'b1;
    end else if (m_phase == 11) begin
      e_sv = 1'b1;
    end
    chk("model", {2'b00, interrupt_ack, port_id, read_strobe, write_strobe, out_port,
                  mot_ack, snap_valid, busy, loc_x, loc_y, bot_info, sensors, snap_count},
                 {2'b00, e_ack, e_port, e_rs, e_ws, e_out, e_mack, e_sv, e_busy,
                  m_loc[0], m_loc[1], m_loc[2], m_loc[3], m_count});
  endtask

  // One clock: drive at negedge, model follows the edge, check at next negedge
  task automatic cycle(input logic r, input logic en, input logic irq,
                       input logic mr, input logic [7:0] mc);
    reset = r; enable = en; interrupt = irq; mot_req = mr; mot_cmd = mc;
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
    if (mot_ack) begin
      mack_cnt++;
      mack_data = out_port;
    end
  endtask

  typedef struct {
    logic       rst, en, irq, mreq;
    logic [7:0] mcmd;
    logic       ack;
    logic [7:0] port;
    logic       rs, ws;
    logic [7:0] outp;
    logic       mack, sv, busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic irq, input logic mreq,
                              input logic [7:0] mcmd, input logic ack,
                              input logic [7:0] port, input logic rs, input logic ws,
                              input logic [7:0] outp, input logic mack,
                              input logic sv, input logic bsy);
    vec_t v;
    v.rst = rst; v.en = 1'b1; v.irq = irq; v.mreq = mreq; v.mcmd = mcmd;
    v.ack = ack; v.port = port; v.rs = rs; v.ws = ws; v.outp = outp;
    v.mack = mack; v.sv = sv; v.busy = bsy;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    int ms;
    reset = 1'b1; enable = 1'b1; interrupt = 1'b0; mot_req = 1'b0; mot_cmd = 8'h00;
    in_port = 8'h00;
    for (int i = 0; i < 4; i++) m_loc[i] = 8'h00;
    resp_val[0] = 8'h11; resp_val[1] = 8'h22; resp_val[2] = 8'h33; resp_val[3] = 8'h44;

    // Canonical snapshot then motor write; each row = inputs, outputs after edge
    //             rst   irq   mreq  cmd    ack   port   rs    ws    out    mack  sv    busy
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0B, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0D, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h12, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].irq, tbl[i].mreq, tbl[i].mcmd);
      chk($sformatf("tbl[%0d]", i),
          {40'd0, interrupt_ack, port_id, read_strobe, write_strobe, out_port, mot_ack, snap_valid, busy},
          {40'd0, tbl[i].ack, tbl[i].port, tbl[i].rs, tbl[i].ws, tbl[i].outp,
           tbl[i].mack, tbl[i].sv, tbl[i].busy});
    end
    chk("snap_regs", {32'd0, loc_x, loc_y, bot_info, sensors}, {32'd0, 32'h11223344});
    chk("snap_count_1", {56'd0, snap_count}, 64'd1);

    // Two motor requests during a service: only the latest is written, after DONE
    mack_cnt = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("mot_overwrite_cnt", 64'(mack_cnt), 64'd1);
    chk("mot_overwrite_data", {56'd0, mack_data}, 64'h02);

    // Interrupt and motor request together: snapshot first, then motor write
    mack_cnt = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("prio_sv", {63'd0, snap_valid}, 64'd1);
    chk("prio_no_mot_yet", 64'(mack_cnt), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("prio_mot_data", {55'd0, mot_ack, out_port}, {55'd0, 1'b1, 8'h77});
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // enable low blocks the service; raising it starts one on the next edge
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("en0_idle", {62'd0, busy, interrupt_ack}, 64'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("en1_ack", {62'd0, busy, interrupt_ack}, 64'd3);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset in RD_SAMPLE of index 2 aborts everything
    resp_val[0] = 8'hA1; resp_val[1] = 8'hB2; resp_val[2] = 8'hC3; resp_val[3] = 8'hD4;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("pre_reset_rdsample2", {54'd0, port_id, read_strobe, 1'b0}, {54'd0, 8'h0C, 1'b1, 1'b0});
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset_abort",
        {port_id, out_port, loc_x, loc_y, bot_info, sensors, snap_count,
         3'd0, interrupt_ack, read_strobe, write_strobe, snap_valid, busy}, 64'd0);

    // 256 services wrap the snapshot counter
    for (int s = 0; s < 256; s++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      if (s == 254) chk("snap_count_ff", {56'd0, snap_count}, 64'hFF);
    end
    chk("snap_count_wrap", {56'd0, snap_count}, 64'h00);

    // Randomized traffic; responder data changes only while the model is idle
    for (int n = 0; n < 3000; n++) begin
      if (m_phase == PH_IDLE)
        for (int i = 0; i < 4; i++) resp_val[i] = 8'($urandom);
      ms = int'($urandom_range(0, 99));
      cycle(ms == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rojobot_io_master.md
ROJOBOT_IO_MASTER -- requirements
Module: rojobot_io_master

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: enable  in  1  service enable; interrupt  in  1  level update-request from bot register block; interrupt_ack  out  1  one-cycle acknowledge.
REQ-003 SHALL have ports: port_id  out  8  I/O address; read_strobe  out  1; write_strobe  out  1; out_port  out  8  write data; in_port  in  8  read data (responder registers it one clock after port_id).
REQ-004 SHALL have ports: mot_req  in  1  motor-command request pulse; mot_cmd  in  8  command; mot_ack  out  1  pulse when command written.
REQ-005 SHALL have ports: loc_x, loc_y, bot_info, sensors  out  8 each  snapshot registers; snap_valid  out  1  pulse; snap_count  out  8  completed snapshots; busy  out  1  state != IDLE.
REQ-006 SHALL use port addresses: LocX 0x0A, LocY 0x0B, BotInfo 0x0C, Sensors 0x0D, MotCtl 0x09, LED[7:0] 0x02, LED[15:8] 0x12.

Function
REQ-007 SHALL implement FSM states IDLE, ACK, RD_SETUP, RD_SAMPLE, WR_LED_LO, WR_LED_HI, DONE, WR_MOT; all bus outputs decoded from registered state/index only (no input-to-output combinational path).
REQ-008 IDLE: interrupt=1 and enable=1 -> ACK; else mot_pend=1 -> WR_MOT; else stay. Interrupt has priority over motor write.
REQ-009 ACK: interrupt_ack=1 for exactly one cycle; rd_idx <= 0; -> RD_SETUP.
REQ-010 RD_SETUP: port_id = 0x0A + rd_idx, read_strobe=0; -> RD_SAMPLE.
REQ-011 RD_SAMPLE: same port_id, read_strobe=1; at clock edge leaving state, in_port captured into loc_x/loc_y/bot_info/sensors for rd_idx 0/1/2/3; rd_idx<3 -> rd_idx+1, RD_SETUP; rd_idx=3 -> WR_LED_LO.
REQ-012 WR_LED_LO: port_id=0x02, out_port=loc_x, write_strobe=1 one cycle; -> WR_LED_HI.
REQ-013 WR_LED_HI: port_id=0x12, out_port=loc_y, write_strobe=1 one cycle; -> DONE.
REQ-014 DONE: snap_valid=1 one cycle; snap_count +1 mod 256 (0xFF -> 0x00); -> IDLE.
REQ-015 Snapshot latency: interrupt sampled in IDLE at edge E -> interrupt_ack in cycle E+1, four reads cycles E+2..E+9, LED writes E+10, E+11, snap_valid E+12; total 13 cycles per service.
REQ-016 Snapshot outputs SHALL update only at their RD_SAMPLE edge and hold otherwise.
REQ-017 mot_req=1 on any cycle SHALL set mot_pend and latch mot_cmd into mot_reg; new mot_req while pending overwrites mot_reg (latest wins); no request dropped silently except by overwrite.
REQ-018 WR_MOT: port_id=0x09, out_port=mot_reg, write_strobe=1, mot_ack=1 one cycle; mot_pend cleared unless mot_req=1 same cycle (then re-set with new cmd); -> IDLE.
REQ-019 interrupt changes while not IDLE SHALL be ignored; level still high on return to IDLE starts a new service.
REQ-020 enable=0 SHALL block new services only; an in-progress sequence completes; motor writes proceed regardless of enable.
REQ-021 read_strobe and write_strobe SHALL never be asserted together; port_id=0x00, out_port=0x00 whenever no strobe phase is active (IDLE, ACK, DONE).

Reset
REQ-022 reset=1 SHALL force state IDLE, rd_idx=0, mot_pend=0, mot_reg=0, all outputs 0 (incl. snapshots, snap_count) at the next clock edge.
REQ-023 reset mid-sequence SHALL abort without further ack/strobe/snap_valid; snapshot registers cleared, not partially kept.

Verification
REQ-024 Responder model returns 0x11/0x22/0x33/0x44 for 0x0A..0x0D; raise interrupt -> ack one cycle after, reads in order, loc_x=0x11, loc_y=0x22, bot_info=0x33, sensors=0x44, writes 0x02<-0x11, 0x12<-0x22, snap_valid 12 cycles after sampling edge.
REQ-025 mot_req with 0x5A in IDLE, interrupt low -> one write 0x09<-0x5A with mot_ack; mot_req 0x01 then 0x02 during a service -> single write of 0x02 after DONE.
REQ-026 interrupt and mot_req same cycle in IDLE -> full snapshot first, then motor write.
REQ-027 enable=0 with interrupt high -> no ack, busy=0; enable=1 -> service starts next cycle.
REQ-028 reset asserted during RD_SAMPLE of rd_idx=2 -> next cycle all outputs 0, no strobes; 256 services -> snap_count wraps to 0x00.
